// File: rtl/divider_pkg.sv
// Shared definitions for the divider1 block: the default operand width and
// the FSM state encoding used by the top level.
package divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/divider1_div_step.sv
// One restoring shift-subtract iteration. Purely combinational: the caller
// holds the partial remainder and the dividend/quotient shift register.
module div_step
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] dividend_out
);

  logic [WIDTH:0] shifted;
  logic           q_bit;

  // Bring the next dividend bit into the partial remainder, then subtract the
  // divisor when it fits. The difference is always below the divisor, so the
  // low WIDTH bits of the subtraction are the whole new remainder.
  always_comb begin
    shifted      = {rem_in, dividend_in[WIDTH-1]};
    q_bit        = (shifted >= {1'b0, divisor});
    rem_out      = q_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
    dividend_out = {dividend_in[WIDTH-2:0], q_bit};
  end

endmodule

// File: rtl/divider1.sv
// divider1: iterative restoring divider, one quotient bit per clock.
// Define DIVIDER1_SIGNED_EN to treat A and B as two's complement; the default
// build divides unsigned operands.
module divider1
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             ready,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem_work;
  logic [WIDTH-1:0] dvd_work;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in      (rem_work),
    .dividend_in (dvd_work),
    .divisor     (divisor),
    .rem_out     (step_rem),
    .dividend_out(step_q)
  );

`ifdef DIVIDER1_SIGNED_EN
  logic neg_q;
  logic neg_r;

  // Divide magnitudes; the final-step results are sign-corrected combinationally
  // so the fixup lands on the same edge that enters DONE.
  always_comb begin
    a_mag = A[WIDTH-1] ? -A : A;
    b_mag = B[WIDTH-1] ? -B : B;
    q_fix = neg_q ? -step_q : step_q;
    r_fix = neg_r ? -step_rem : step_rem;
  end

  // Remember the result signs from the operands captured at start.
  always_ff @(posedge clk) begin
    if (reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start) begin
      neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
      neg_r <= A[WIDTH-1];
    end
  end
`else
  // Unsigned build: operands and results pass straight through.
  always_comb begin
    a_mag = A;
    b_mag = B;
    q_fix = step_q;
    r_fix = step_rem;
  end
`endif

  // Control FSM plus working registers and registered results. A start in any
  // state restarts from scratch, which is also how a busy division is aborted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      rem_work    <= '0;
      dvd_work    <= '0;
      divisor     <= '0;
      Quotient    <= '0;
      Remainder   <= '0;
      ready       <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (start) begin
      count    <= '0;
      rem_work <= '0;
      dvd_work <= a_mag;
      divisor  <= b_mag;
      if (B == '0) begin
        state       <= DONE;
        Quotient    <= '1;
        Remainder   <= A;
        ready       <= 1'b1;
        div_by_zero <= 1'b1;
      end else begin
        state       <= BUSY;
        Remainder   <= '0;
        ready       <= 1'b0;
        div_by_zero <= 1'b0;
      end
    end else begin
      case (state)
        BUSY: begin
          rem_work <= step_rem;
          dvd_work <= step_q;
          count    <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            state     <= DONE;
            Quotient  <= q_fix;
            Remainder <= r_fix;
            ready     <= 1'b1;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: doc/divider1.md
DIVIDER1 -- requirements
Module: divider1

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand and result width in bits.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  one-cycle pulse; loads operands and begins a division.
REQ-005 SHALL have port: A  input  WIDTH  dividend, sampled only on the start cycle.
REQ-006 SHALL have port: B  input  WIDTH  divisor, sampled only on the start cycle.
REQ-007 SHALL have port: Quotient  output  WIDTH  registered result, valid while ready=1.
REQ-008 SHALL have port: Remainder  output  WIDTH  registered result, valid while ready=1.
REQ-009 SHALL have port: ready  output  1  high while results are valid; low in IDLE and BUSY.
REQ-010 SHALL have port: div_by_zero  output  1  high with ready when the sampled B was 0.

Function
REQ-011 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-012 SHALL, in any state, when start=1 and reset=0: latch A and B; clear Remainder and the iteration counter; enter BUSY, or enter DONE directly if B=0.
REQ-013 SHALL perform one restoring shift-subtract step per BUSY cycle: shift {partial remainder, dividend MSB} left; if the WIDTH+1-bit partial remainder >= divisor, subtract the divisor and shift in quotient bit 1, else shift in 0.
REQ-014 SHALL leave BUSY for DONE after exactly WIDTH steps, so ready rises on the (WIDTH+1)th rising edge after the start edge (33 cycles at WIDTH=32).
REQ-015 SHALL, for B=0, assert ready and div_by_zero one edge after start, with Quotient = all ones and Remainder = A.
REQ-016 SHALL hold DONE, results and ready stable until the next start or reset; the FSM never returns to IDLE except by reset.
REQ-017 SHALL treat start during BUSY as an abort and restart with the new operands; the partial result is discarded.
REQ-018 SHALL clear div_by_zero on every start and keep it low for nonzero divisors.
REQ-019 SHALL satisfy A = Quotient*B + Remainder, with Remainder < B (unsigned build).

Reset
REQ-020 SHALL, on reset=1 at a clock edge, enter IDLE and drive Quotient=0, Remainder=0, ready=0, div_by_zero=0.
REQ-021 SHALL give reset priority over start when both are high on the same edge.
REQ-022 SHALL abandon an in-progress division on reset, with no output side effects.

Configuration
REQ-023 SHALL support macro DIVIDER1_SIGNED_EN; when it is undefined, operands and results are unsigned.
REQ-024 SHALL, with DIVIDER1_SIGNED_EN defined, treat A and B as two's complement: divide magnitudes, negate Quotient when the operand signs differ, and give Remainder the sign of A.
REQ-025 SHALL, with DIVIDER1_SIGNED_EN defined, apply the sign fixup on the edge entering DONE with no extra latency; -2^(WIDTH-1)/-1 yields Quotient = 0x80000000 and Remainder = 0.

Structure
REQ-026 SHALL take the FSM state encoding (IDLE/BUSY/DONE) and the default WIDTH constant from shared package divider_pkg.
REQ-027 SHALL contain one sub-module, div_step: combinational compare/subtract/shift for one iteration, with no state.
REQ-028 SHALL size the iteration counter as clog2(WIDTH)+1 bits.

Verification
REQ-029 SHALL cover: reset, then idle with no start -> ready=0, Quotient=0, Remainder=0.
REQ-030 SHALL cover: start A=100, B=7 -> after 33 edges ready=1, Quotient=14, Remainder=2, div_by_zero=0.
REQ-031 SHALL cover: start A=0xFFFFFFFF, B=1 -> Quotient=0xFFFFFFFF, Remainder=0; then A=5, B=9 -> Quotient=0, Remainder=5.
REQ-032 SHALL cover: start A=42, B=0 -> ready and div_by_zero high on the next edge, Quotient=0xFFFFFFFF, Remainder=42.
REQ-033 SHALL cover: start A=100, B=7; re-start at cycle 10 with A=50, B=5 -> ready exactly 33 edges after the second start, Quotient=10, Remainder=0; reset asserted at cycle 20 of a further run -> outputs 0, ready stays 0.
REQ-034 SHALL cover, signed build only: A=-7, B=2 -> Quotient=-3, Remainder=-1; A=0x80000000, B=-1 -> Quotient=0x80000000, Remainder=0.
